// File: rtl/input_queue.sv
// input_queue: per-inport first-word-fall-through flit buffer that computes each flit's route when the flit is written.
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-high reset
//   flit_din       in   48-bit flit {dst_x[47:44], dst_y[43:40], payload[39:0]}
//   write_strobe   in   flit_din is valid this cycle
//   credit_out     out  one-cycle credit pulse issued after each accepted dequeue
//   flit_dout      out  head flit; 0 while the buffer is empty
//   request_vector out  one-hot head route {pe, west, south}; 0 while the buffer is empty
//   done_strobe    in   head flit consumed this cycle
//   occupancy      out  number of stored flits, 0..DEPTH
//   overflow       out  sticky flag, set when a flit is dropped
module input_queue #(
    parameter logic [3:0] X_LOCAL = 4'd0,
    parameter logic [3:0] Y_LOCAL = 4'd0,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [47:0]      flit_din,
    input  logic             write_strobe,
    output logic             credit_out,
    output logic [47:0]      flit_dout,
    output logic [2:0]       request_vector,
    input  logic             done_strobe,
    output logic [PTR_W:0]   occupancy,
    output logic             overflow
);
    localparam logic [PTR_W:0] full_cnt = (PTR_W+1)'(DEPTH);
    logic [50:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic empty, full, deq, wr_ok;
    logic [2:0] route;
    // A full buffer still takes a write when the head leaves in the same cycle.
    always_comb begin
        empty = occupancy == '0;
        full = occupancy == full_cnt;
        deq = done_strobe && !empty;
        wr_ok = write_strobe && (!full || deq);
        route = flit_din[47:44] != X_LOCAL ? 3'b010 : flit_din[43:40] != Y_LOCAL ? 3'b001 : 3'b100;
        flit_dout = empty ? '0 : mem[rd_ptr][47:0];
        request_vector = empty ? '0 : mem[rd_ptr][50:48];
    end
    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr] <= {route, flit_din};
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occupancy <= '0;
            credit_out <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(wr_ok);
            rd_ptr <= rd_ptr + PTR_W'(deq);
            occupancy <= occupancy + (PTR_W+1)'(wr_ok) - (PTR_W+1)'(deq);
            credit_out <= deq;
            overflow <= overflow | (write_strobe & ~wr_ok);
        end
endmodule
